// File: rtl/ler_palavra_if.sv
`default_nettype none
// ============================================================================
//  Module      : ler_palavra_if
//  Description : Bundle of the request, RAM read-port and result signals of
//                the framebuffer word reader. The master side issues
//                requests and returns RAM read data. The slave side is the
//                reader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ler_palavra_if;

    logic        start;
    logic [31:0] endereco_base;
    logic        q;
    logic [11:0] rdaddress;
    logic        rden;
    logic [31:0] dados_out;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output endereco_base,
        output q,
        input  rdaddress,
        input  rden,
        input  dados_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  endereco_base,
        input  q,
        output rdaddress,
        output rden,
        output dados_out,
        output busy,
        output done
    );

endinterface

`default_nettype wire

// File: rtl/ler_palavra.sv
`default_nettype none
// ============================================================================
//  Module      : ler_palavra
//  Description : Framebuffer word reader. On start it reads 32 consecutive
//                1-bit pixels from a 4096x1 RAM, beginning at a base address.
//                It packs them MSB-first into a 32-bit word and pulses done
//                for one cycle.
//  Options     : LER_WRAP_EN - when defined, addresses wrap modulo 4096.
//                When undefined, issues past address 4095 are suppressed
//                (rden=0, rdaddress=0) and read back as 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ler_palavra #(
    parameter int RD_LAT = 1            // RAM read latency, 1 or 2 cycles
) (
    input  wire          clock,
    input  wire          reset_n,
    ler_palavra_if.slave bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_read  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [5:0] c_last_idx = 6'd31;

    // FSM state
    logic [1:0]      state_q, state_d;

    // datapath registers
    logic [11:0]     base_q, base_d;        // latched start address
    logic [5:0]      idx_q, idx_d;          // index of the issue currently on rdaddress
    logic [5:0]      cap_q, cap_d;          // number of bits captured so far
    logic [RD_LAT:0] vld_q, vld_d;          // issue tracking, one slot per cycle of latency
    logic [RD_LAT:0] oob_q, oob_d;          // marks tracked slots that were out of range
    logic [31:0]     shift_q, shift_d;      // word under assembly

    // registered outputs
    logic [11:0]     rdaddress_q, rdaddress_d;
    logic            rden_q, rden_d;
    logic [31:0]     dados_q, dados_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // combinational helpers
    logic            w_issue;
    logic [11:0]     w_issue_base;
    logic [5:0]      w_issue_idx;
    logic [11:0]     w_issue_addr;
    logic            w_issue_oob;
    logic            w_capture;
    logic            w_cap_bit;
    logic            w_last_capture;
    logic            w_unused_base_hi;

    // Only 12 address bits reach the RAM; the upper bits are deliberately dropped.
    assign w_unused_base_hi = ^bus.endereco_base[31:12];

    // Decide whether an address is issued on the coming edge, and which one.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_base = base_q;
        w_issue_idx  = idx_q + 6'd1;
        if (state_q == c_st_idle) begin
            // Issue 0 goes out on the same edge that accepts start.
            w_issue      = bus.start;
            w_issue_base = bus.endereco_base[11:0];
            w_issue_idx  = 6'd0;
        end else if (state_q == c_st_read) begin
            w_issue = (idx_q != c_last_idx);
        end
    end

`ifdef LER_WRAP_EN
    // Address arithmetic wraps modulo 4096; every issue is a real read.
    always_comb begin
        w_issue_addr = w_issue_base + {6'd0, w_issue_idx};
        w_issue_oob  = 1'b0;
    end
`else
    logic [12:0] w_issue_sum;

    // Addresses past 4095 are suppressed and later read back as zero.
    always_comb begin
        w_issue_sum  = {1'b0, w_issue_base} + {7'd0, w_issue_idx};
        w_issue_oob  = w_issue_sum[12];
        w_issue_addr = w_issue_oob ? 12'd0 : w_issue_sum[11:0];
    end
`endif

    // A capture happens when a tracked issue reaches the end of the latency pipe.
    assign w_capture      = vld_q[RD_LAT];
    assign w_cap_bit      = bus.q & ~oob_q[RD_LAT];
    assign w_last_capture = w_capture && (cap_q == c_last_idx);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (bus.start) begin
                    state_d = c_st_read;
                end
            end
            c_st_read: begin
                if (idx_q == c_last_idx) begin
                    state_d = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_last_capture) begin
                    state_d = c_st_done;
                end
            end
            c_st_done: begin
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Datapath next values: counters, latency pipe and shift register.
    always_comb begin
        base_d  = base_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        vld_d   = {vld_q[RD_LAT-1:0], w_issue};
        oob_d   = {oob_q[RD_LAT-1:0], w_issue & w_issue_oob};
        shift_d = shift_q;

        if (state_q == c_st_idle && bus.start) begin
            base_d = bus.endereco_base[11:0];
            idx_d  = 6'd0;
            cap_d  = 6'd0;
        end else if (w_issue) begin
            idx_d = w_issue_idx;
        end

        // New bits enter on the LSB side so the first one ends up at [31].
        if (w_capture) begin
            shift_d = {shift_q[30:0], w_cap_bit};
            cap_d   = cap_q + 6'd1;
        end
    end

    // Output logic, computed from the upcoming state so outputs are registered.
    always_comb begin
        rden_d      = w_issue & ~w_issue_oob;
        rdaddress_d = rdaddress_q;
        dados_d     = dados_q;
        busy_d      = (state_d == c_st_read) || (state_d == c_st_drain);
        done_d      = (state_d == c_st_done);

        if (w_issue) begin
            rdaddress_d = w_issue_addr;
        end else if (state_d == c_st_idle) begin
            rdaddress_d = 12'd0;
        end

        // The result is published whole, together with the done pulse.
        if (state_d == c_st_done) begin
            dados_d = shift_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
            vld_q   <= '0;
            oob_q   <= '0;
            shift_q <= '0;
        end else begin
            base_q  <= base_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            vld_q   <= vld_d;
            oob_q   <= oob_d;
            shift_q <= shift_d;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdaddress_q <= '0;
            rden_q      <= 1'b0;
            dados_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rdaddress_q <= rdaddress_d;
            rden_q      <= rden_d;
            dados_q     <= dados_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rdaddress = rdaddress_q;
    assign bus.rden      = rden_q;
    assign bus.dados_out = dados_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ler_palavra.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ler_palavra
//  Description : Directed bench for ler_palavra. Two readers are instantiated,
//                one with RD_LAT=1 and one with RD_LAT=2, each with its own
//                behavioural 4096x1 RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ler_palavra;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    ler_palavra_if bus1 ();
    ler_palavra_if bus2 ();

    ler_palavra #(.RD_LAT(1)) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    ler_palavra #(.RD_LAT(2)) u_dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    // RAM models: latency 1 for dut1, latency 2 for dut2.
    logic mem1 [0:4095];
    logic mem2 [0:4095];
    logic m1_q  = 1'b0;
    logic m2_d1 = 1'b0;
    logic m2_q  = 1'b0;

    always @(posedge clock) begin
        if (bus1.rden) m1_q <= mem1[bus1.rdaddress];
    end

    always @(posedge clock) begin
        if (bus2.rden) m2_d1 <= mem2[bus2.rdaddress];
        m2_q <= m2_d1;
    end

    assign bus1.q = m1_q;
    assign bus2.q = m2_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Run one read on dut1 (sel=0) or dut2 (sel=1) and observe a 75-cycle window.
    // k counts cycles after the accepting edge E0 (k=0 is the cycle after E0).
    // If poke_k >= 0, a second start with base 500 is pulsed at cycle poke_k.
    task automatic do_read(input int sel, input logic [31:0] base, input int poke_k,
                           output int done_k, output int done_cnt, output int rden_cnt,
                           output int overlap, output int addr_err, output logic busy0,
                           output logic [31:0] word, output logic [31:0] word_end);
        logic [11:0] exp_addr;
        logic        s_rden, s_done, s_busy;
        logic [11:0] s_addr;
        logic [31:0] s_dout;
        exp_addr = base[11:0];
        done_k   = -1;
        done_cnt = 0;
        rden_cnt = 0;
        overlap  = 0;
        addr_err = 0;
        busy0    = 1'b0;
        word     = '0;
        @(negedge clock);
        if (sel == 0) begin
            bus1.start = 1'b1;
            bus1.endereco_base = base;
        end else begin
            bus2.start = 1'b1;
            bus2.endereco_base = base;
        end
        for (int k = 0; k < 75; k++) begin
            @(negedge clock);
            if (k == 0) begin
                bus1.start = 1'b0;
                bus2.start = 1'b0;
            end
            if (poke_k >= 0 && k == poke_k) begin
                bus1.start = 1'b1;
                bus1.endereco_base = 32'd500;
            end
            if (poke_k >= 0 && k == poke_k + 1) bus1.start = 1'b0;
            s_rden = (sel == 0) ? bus1.rden      : bus2.rden;
            s_addr = (sel == 0) ? bus1.rdaddress : bus2.rdaddress;
            s_done = (sel == 0) ? bus1.done      : bus2.done;
            s_busy = (sel == 0) ? bus1.busy      : bus2.busy;
            s_dout = (sel == 0) ? bus1.dados_out : bus2.dados_out;
            if (k == 0) busy0 = s_busy;
            if (s_rden) begin
                if (s_addr !== exp_addr) addr_err++;
                exp_addr = exp_addr + 12'd1;
                rden_cnt++;
            end
            if (s_done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    word   = s_dout;
                end
            end
            if (s_done && s_busy) overlap++;
        end
        word_end = (sel == 0) ? bus1.dados_out : bus2.dados_out;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          done_k, done_cnt, rden_cnt, overlap, addr_err, ndone;
        logic        busy0;
        logic [31:0] word, word_end;

        for (int k = 0; k < 4096; k++) begin
            mem1[k] = (k < 1024);
            mem2[k] = k[0];
        end
        bus1.start = 1'b0;
        bus1.endereco_base = '0;
        bus2.start = 1'b0;
        bus2.endereco_base = '0;
        reset_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_rdaddress", {20'd0, bus1.rdaddress}, 32'd0);
        check("rst_rden",      {31'd0, bus1.rden},      32'd0);
        check("rst_dados_out", bus1.dados_out,          32'd0);
        check("rst_busy",      {31'd0, bus1.busy},      32'd0);
        check("rst_done",      {31'd0, bus1.done},      32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Base 0 over the 1024-ones region
        do_read(0, 32'd0, -1, done_k, done_cnt, rden_cnt, overlap, addr_err, busy0, word, word_end);
        check("t1_done_cycle", done_k,   33);
        check("t1_word",       word,     32'hFFFF_FFFF);
        check("t1_rden_cycles", rden_cnt, 32);
        check("t1_done_count", done_cnt, 1);
        check("t1_busy_done_overlap", overlap, 0);
        check("t1_busy_first", {31'd0, busy0}, 32'd1);
        check("t1_addr_seq",   addr_err, 0);
        check("t1_word_hold",  word_end, 32'hFFFF_FFFF);

        // Base 1008 straddles the end of the ones region
        do_read(0, 32'd1008, -1, done_k, done_cnt, rden_cnt, overlap, addr_err, busy0, word, word_end);
        check("t2_done_cycle", done_k,   33);
        check("t2_word",       word,     32'hFFFF_0000);
        check("t2_word_hold",  word_end, 32'hFFFF_0000);

        // All ones, base 4080: crosses the top of the address space
        for (int k = 0; k < 4096; k++) mem1[k] = 1'b1;
        do_read(0, 32'd4080, -1, done_k, done_cnt, rden_cnt, overlap, addr_err, busy0, word, word_end);
        check("t3_done_cycle", done_k,   33);
        check("t3_addr_seq",   addr_err, 0);
`ifdef LER_WRAP_EN
        check("t3_word",        word,     32'hFFFF_FFFF);
        check("t3_rden_cycles", rden_cnt, 32);
`else
        check("t3_word",        word,     32'hFFFF_0000);
        check("t3_rden_cycles", rden_cnt, 16);
`endif

        // Start pulsed mid-read with a different base must be ignored
        for (int k = 0; k < 4096; k++) mem1[k] = (k < 1024);
        do_read(0, 32'd1008, 10, done_k, done_cnt, rden_cnt, overlap, addr_err, busy0, word, word_end);
        check("t4_done_count", done_cnt, 1);
        check("t4_done_cycle", done_k,   33);
        check("t4_word",       word,     32'hFFFF_0000);
        check("t4_rden_cycles", rden_cnt, 32);

        // Reset in the middle of a read aborts it
        @(negedge clock);
        bus1.start = 1'b1;
        bus1.endereco_base = 32'd0;
        @(negedge clock);
        bus1.start = 1'b0;
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_rdaddress", {20'd0, bus1.rdaddress}, 32'd0);
        check("abort_rden",      {31'd0, bus1.rden},      32'd0);
        check("abort_dados_out", bus1.dados_out,          32'd0);
        check("abort_busy",      {31'd0, bus1.busy},      32'd0);
        check("abort_done",      {31'd0, bus1.done},      32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus1.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_read(0, 32'd0, -1, done_k, done_cnt, rden_cnt, overlap, addr_err, busy0, word, word_end);
        check("t5_done_cycle", done_k, 33);
        check("t5_word",       word,   32'hFFFF_FFFF);

        // RD_LAT=2 reader over alternating bits
        do_read(1, 32'd0, -1, done_k, done_cnt, rden_cnt, overlap, addr_err, busy0, word, word_end);
        check("t6_done_cycle",  done_k,   34);
        check("t6_word",        word,     32'h5555_5555);
        check("t6_rden_cycles", rden_cnt, 32);
        check("t6_done_count",  done_cnt, 1);
        check("t6_busy_done_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
